// File: rtl/spi_pkg.sv
// spi_pkg: register map, bit positions and FSM states shared by the SPI master and slave.
package spi_pkg;
   localparam logic [3:0] REG_CTRL = 4'h0, REG_DATA = 4'h4, REG_STATUS = 4'h8;
   localparam int CTRL_EN = 0, CTRL_CPOL = 1, CTRL_CPHA = 2;
   localparam int ST_BUSY = 0, ST_RX_VALID = 1, ST_TX_PENDING = 2, ST_OVERRUN = 3;
   typedef enum logic {IDLE, ACTIVE} spi_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-flop synchronizer with one-cycle rise/fall pulses gated by arm.
module spi_sync_edge #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic arm,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [N-1:0] sync;
   logic prev;
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[N-2:0], d};
         prev <= sync[N-1];
      end
   end
   assign q = sync[N-1];
   assign rise = arm & q & ~prev;
   assign fall = arm & ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, any CPOL/CPHA, one byte per 8 SCK cycles, CPU access over the register bus.
module spi_slave import spi_pkg::*; #(
   parameter int SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_TX = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] data_o,
   input  logic        spi_sck,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso
);
   spi_state_t state;
   logic [2:0] ctrl, bit_cnt;
   logic [7:0] tx_buf, rx_data, shreg, next_tx;
   logic tx_pending, rx_valid, overrun, cpol_l, cpha_l;
   logic ss_q, ss_rise, ss_fall, sck_q, sck_rise, sck_fall, mosi_q;
   logic lead, trail, sample, drive, wr_ctrl, wr_data, wr_stat, unused;
   logic [SYNC_STAGES-1:0] mosi_sync;

   spi_sync_edge #(.N(SYNC_STAGES)) u_ss (
      .clk(clk), .rst(rst), .d(spi_ss), .arm(1'b1), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
   spi_sync_edge #(.N(SYNC_STAGES)) u_sck (
      .clk(clk), .rst(rst), .d(spi_sck), .arm(ctrl[CTRL_EN] & ~ss_q), .q(sck_q), .rise(sck_rise), .fall(sck_fall));

   always_ff @(posedge clk) begin
      if (!rst) mosi_sync <= '0;
      else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_q = mosi_sync[SYNC_STAGES-1];

   // edge roles follow the mode latched at frame start, not the live CTRL bits
   assign lead = cpol_l ? sck_fall : sck_rise;
   assign trail = cpol_l ? sck_rise : sck_fall;
   assign sample = cpha_l ? trail : lead;
   assign drive = cpha_l ? lead : trail;
   assign next_tx = tx_pending ? tx_buf : IDLE_TX;
   assign wr_ctrl = we_i & sel_i[0] & (addr_i[3:0] == REG_CTRL);
   assign wr_data = we_i & sel_i[0] & (addr_i[3:0] == REG_DATA);
   assign wr_stat = we_i & sel_i[0] & (addr_i[3:0] == REG_STATUS);
   assign unused = ^{data_i[31:8], addr_i[31:4], sel_i[3:1], sck_q};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         ctrl <= '0;
         tx_buf <= '0;
         rx_data <= '0;
         shreg <= '0;
         bit_cnt <= '0;
         tx_pending <= 1'b0;
         rx_valid <= 1'b0;
         overrun <= 1'b0;
         cpol_l <= 1'b0;
         cpha_l <= 1'b0;
         spi_miso <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= data_i[2:0];
         if (wr_stat && data_i[ST_RX_VALID]) rx_valid <= 1'b0;
         if (wr_stat && data_i[ST_OVERRUN]) overrun <= 1'b0;
         if (state == IDLE) begin
            if (ss_fall && ctrl[CTRL_EN]) begin
               state <= ACTIVE;
               cpol_l <= ctrl[CTRL_CPOL];
               cpha_l <= ctrl[CTRL_CPHA];
               shreg <= next_tx;
               tx_pending <= 1'b0;
               bit_cnt <= '0;
               spi_miso <= ctrl[CTRL_CPHA] ? 1'b0 : next_tx[7];
            end
         end else if (ss_rise || !ctrl[CTRL_EN]) begin
            state <= IDLE;
            bit_cnt <= '0;
            spi_miso <= 1'b0;
         end else begin
            if (drive) spi_miso <= shreg[7];
            if (sample) begin
               bit_cnt <= bit_cnt + 3'd1;
               shreg <= (bit_cnt == 3'd7) ? next_tx : {shreg[6:0], mosi_q};
               if (bit_cnt == 3'd7) begin
                  rx_data <= {shreg[6:0], mosi_q};
                  rx_valid <= 1'b1;
                  if (rx_valid) overrun <= 1'b1;
                  tx_pending <= 1'b0;
               end
            end
         end
         // a write landing on a reload cycle leaves the new byte pending
         if (wr_data) begin
            tx_buf <= data_i[7:0];
            tx_pending <= 1'b1;
         end
      end
   end

   assign data_o = (addr_i[3:0] == REG_CTRL) ? {29'h0, ctrl} :
                   (addr_i[3:0] == REG_DATA) ? {24'h0, rx_data} :
                   (addr_i[3:0] == REG_STATUS) ? {28'h0, overrun, tx_pending, rx_valid, state == ACTIVE} : 32'h0;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench-side SPI master plus register-level model, scored through expect/observe queues.
module tb_spi_slave;
   import spi_pkg::*;
   localparam int H = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic [31:0] data_i = '0, addr_i = '0, data_o;
   logic we_i = 1'b0;
   logic [3:0] sel_i = '0;
   logic spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0, spi_miso;
   string exp_n[$], act_n[$];
   logic [31:0] exp_v[$], act_v[$];
   logic [7:0] mo_q[$];
   int n_cmp = 0, n_bad = 0;
   logic [7:0] m_tx_buf = '0, m_rx_data = '0;
   logic [2:0] m_ctrl = '0;
   logic m_tx_pending = 1'b0, m_rx_valid = 1'b0, m_overrun = 1'b0;

   always #5 clk = ~clk;

   spi_slave dut (
      .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i), .sel_i(sel_i),
      .data_o(data_o), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

   always @(negedge clk) begin
      if (act_v.size() > 0) begin
         string an, en;
         logic [31:0] av, ev;
         an = act_n.pop_front();
         av = act_v.pop_front();
         n_cmp++;
         if (exp_v.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %h, nothing expected", an, av);
         end else begin
            en = exp_n.pop_front();
            ev = exp_v.pop_front();
            if (av !== ev || an != en) begin
               n_bad++;
               $display("FAIL %s: got %h, expected %h (%s)", an, av, ev, en);
            end
         end
      end
   end

   function automatic void expect_v(input string nm, input logic [31:0] v);
      exp_n.push_back(nm);
      exp_v.push_back(v);
   endfunction

   function automatic void observe(input string nm, input logic [31:0] v);
      act_n.push_back(nm);
      act_v.push_back(v);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      addr_i = {28'h0, a};
      data_i = d;
      sel_i = s;
      we_i = 1'b1;
      tick(1);
      we_i = 1'b0;
      if (s[0] && a == REG_CTRL) m_ctrl = d[2:0];
      if (s[0] && a == REG_DATA) begin
         m_tx_buf = d[7:0];
         m_tx_pending = 1'b1;
      end
      if (s[0] && a == REG_STATUS && d[1]) m_rx_valid = 1'b0;
      if (s[0] && a == REG_STATUS && d[3]) m_overrun = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input string nm, input logic [31:0] e);
      addr_i = {28'h0, a};
      expect_v(nm, e);
      #1 observe(nm, data_o);
      tick(1);
   endtask

   task automatic set_mode(input logic [1:0] md);
      wr(REG_CTRL, {29'h0, md[0], md[1], 1'b1}, 4'h1);
   endtask

   task automatic check_regs(input string tag);
      rd(REG_STATUS, {tag, " status"}, {28'h0, m_overrun, m_tx_pending, m_rx_valid, 1'b0});
      rd(REG_DATA, {tag, " rx_data"}, {24'h0, m_rx_data});
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b, input int n);
      mo_q.delete();
      mo_q.push_back(a);
      if (n > 1) mo_q.push_back(b);
   endtask

   // SPI master driving mo_q MSB first; hook issues a STATUS rx_valid clear landing on the last sample edge
   task automatic frame(input logic [1:0] md, input int nbits, input bit hook, input string tag);
      logic cpol, cpha;
      logic [7:0] cap, cur;
      cpol = md[1];
      cpha = md[0];
      cap = '0;
      spi_sck = cpol;
      spi_ss = 1'b1;
      tick(2 * H);
      spi_ss = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         cur = mo_q[i / 8];
         if (!cpha) begin
            spi_mosi = cur[3'(7 - i % 8)];
            tick(H);
            spi_sck = ~cpol;
            cap = {cap[6:0], spi_miso};
            if (hook && i == nbits - 1) begin
               tick(2);
               addr_i = {28'h0, REG_STATUS};
               data_i = 32'h2;
               sel_i = 4'h1;
               we_i = 1'b1;
               tick(1);
               we_i = 1'b0;
               tick(H - 3);
            end else tick(H);
            spi_sck = cpol;
         end else begin
            tick(H);
            spi_sck = ~cpol;
            spi_mosi = cur[3'(7 - i % 8)];
            tick(H);
            spi_sck = cpol;
            cap = {cap[6:0], spi_miso};
         end
         if (i % 8 == 7) observe($sformatf("%s miso%0d", tag, i / 8), {24'h0, cap});
      end
      tick(H);
      spi_ss = 1'b1;
      tick(2 * H);
   endtask

   // model: first byte carries a pending tx byte, later bytes IDLE_TX; each whole byte lands in rx_data
   task automatic run_frame(input logic [1:0] md, input int nbits, input bit hook, input string tag);
      int nb;
      nb = nbits / 8;
      for (int k = 0; k < nb; k++)
         expect_v($sformatf("%s miso%0d", tag, k), {24'h0, (k == 0 && m_tx_pending) ? m_tx_buf : 8'h00});
      m_tx_pending = 1'b0;
      for (int k = 0; k < nb; k++) begin
         if (m_rx_valid) m_overrun = 1'b1;
         m_rx_valid = 1'b1;
         m_rx_data = mo_q[k];
      end
      frame(md, nbits, hook, tag);
      check_regs(tag);
   endtask

   initial begin
      tick(1);
      rst = 1'b0;
      tick(3);
      rd(REG_CTRL, "rst ctrl", 32'h0);
      rd(REG_DATA, "rst data", 32'h0);
      rd(REG_STATUS, "rst status", 32'h0);
      expect_v("rst miso", 32'h0);
      observe("rst miso", {31'h0, spi_miso});
      rst = 1'b1;
      tick(2);

      set_mode(2'd0);
      rd(REG_CTRL, "ctrl mode0", 32'h1);
      wr(REG_DATA, 32'hA5, 4'h1);
      load(8'h3C, 8'h00, 1);
      run_frame(2'd0, 8, 1'b0, "mode0");
      for (int m = 1; m < 4; m++) begin
         wr(REG_STATUS, 32'hA, 4'h1);
         set_mode(2'(m));
         wr(REG_DATA, 32'hA5, 4'h1);
         run_frame(2'(m), 8, 1'b0, $sformatf("mode%0d", m));
      end

      wr(REG_STATUS, 32'hA, 4'h1);
      set_mode(2'd0);
      wr(REG_DATA, 32'h5A, 4'h1);
      load(8'h11, 8'h22, 2);
      run_frame(2'd0, 16, 1'b0, "overrun");
      wr(REG_STATUS, 32'hA, 4'h1);
      check_regs("w1c");

      load(8'hC3, 8'h00, 1);
      run_frame(2'd0, 8, 1'b0, "idle_tx");
      wr(REG_STATUS, 32'hA, 4'h1);

      wr(REG_DATA, 32'h77, 4'h1);
      load(8'hE7, 8'h00, 1);
      run_frame(2'd0, 5, 1'b0, "abort");
      load(8'h81, 8'h00, 1);
      run_frame(2'd0, 8, 1'b0, "realign");

      wr(REG_STATUS, 32'hA, 4'h1);
      load(8'h96, 8'h00, 1);
      run_frame(2'd0, 8, 1'b1, "setwins");

      for (int it = 0; it < 20; it++) begin
         logic [1:0] md;
         int nb, nbits;
         md = 2'($urandom_range(0, 3));
         set_mode(md);
         if ($urandom_range(0, 1) == 1) wr(REG_DATA, $urandom, 4'hF);
         if ($urandom_range(0, 1) == 1) wr(REG_STATUS, 32'hA, 4'h1);
         nb = $urandom_range(1, 3);
         mo_q.delete();
         repeat (nb) mo_q.push_back(8'($urandom));
         nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb * 8 - 1) : nb * 8;
         run_frame(md, nbits, 1'b0, $sformatf("rnd%0d", it));
      end

      set_mode(2'd0);
      wr(REG_DATA, 32'hC0, 4'h1);
      spi_sck = 1'b0;
      tick(2 * H);
      spi_ss = 1'b0;
      tick(6);
      rd(REG_STATUS, "mid busy", {28'h0, m_overrun, 1'b0, m_rx_valid, 1'b1});
      expect_v("mid miso", 32'h1);
      observe("mid miso", {31'h0, spi_miso});
      spi_mosi = 1'b1;
      spi_sck = 1'b1;
      tick(H);
      rst = 1'b0;
      tick(1);
      expect_v("rstmid miso", 32'h0);
      observe("rstmid miso", {31'h0, spi_miso});
      rd(REG_CTRL, "rstmid ctrl", 32'h0);
      rd(REG_DATA, "rstmid data", 32'h0);
      rd(REG_STATUS, "rstmid status", 32'h0);
      {m_tx_buf, m_rx_data, m_ctrl, m_tx_pending, m_rx_valid, m_overrun} = '0;
      spi_ss = 1'b1;
      spi_sck = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(2 * H);
      set_mode(2'd0);
      wr(REG_DATA, 32'h5C, 4'h1);
      load(8'hA3, 8'h00, 1);
      run_frame(2'd0, 8, 1'b0, "recover");

      for (int w = 0; w < 400 && act_v.size() > 0; w++) tick(1);
      tick(2);
      if (act_v.size() != 0 || exp_v.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d observed and %0d expected left, required 0 and 0", act_v.size(), exp_v.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
